// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image-view controller: loads an IMG_W x IMG_H image and streams a WIN x WIN
// fit or zoom view on command. Define LCD_WRAP_EN to make zoom-window shifts wrap instead of clamp.
module lcd_ctrl_param #(
    parameter int IMG_W = 12,
    parameter int IMG_H = 9,
    parameter int WIN   = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] datain,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int N  = IMG_W * IMG_H;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(WIN);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SX = IMG_W / WIN;
    localparam int SY = IMG_H / WIN;

    localparam logic [XW-1:0] X_MAX     = XW'(IMG_W - WIN);
    localparam logic [YW-1:0] Y_MAX     = YW'(IMG_H - WIN);
    localparam logic [XW-1:0] X_CTR     = XW'(IMG_W / 2 - WIN / 2);
    localparam logic [YW-1:0] Y_CTR     = YW'(IMG_H / 2 - WIN / 2);
    localparam logic [CW-1:0] LAST_IDX  = CW'(WIN - 1);
    localparam logic [AW-1:0] FILL_LAST = AW'(N - 1);

`ifdef LCD_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_OUT
    } state_t;

    typedef enum logic [2:0] {
        CMD_LOAD        = 3'd0,
        CMD_REFLASH     = 3'd1,
        CMD_SHIFT_RIGHT = 3'd2,
        CMD_SHIFT_LEFT  = 3'd3,
        CMD_SHIFT_UP    = 3'd4,
        CMD_SHIFT_DOWN  = 3'd5,
        CMD_ZOOM_FIT    = 3'd6,
        CMD_ZOOM_IN     = 3'd7
    } cmd_t;

    typedef enum logic {
        MODE_FIT,
        MODE_ZOOM
    } mode_t;

    state_t        state, state_nxt;
    mode_t         mode;
    logic [XW-1:0] x0, x_right, x_left;
    logic [YW-1:0] y0, y_down, y_up;
    logic [CW-1:0] r, c;
    logic          view_done;
    logic [AW-1:0] fill_addr;
    logic [AW-1:0] px, py, rd_addr;
    logic          accept, last_beat, fill_last;
    logic [DW-1:0] mem [N];

    assign last_beat = (r == LAST_IDX) && (c == LAST_IDX);
    assign fill_last = (fill_addr == FILL_LAST);

    // At a limit the origin either holds or jumps to the opposite limit.
    assign x_right = (x0 == X_MAX) ? (WRAP_EN ? '0 : x0)    : x0 + XW'(1);
    assign x_left  = (x0 == '0)    ? (WRAP_EN ? X_MAX : x0) : x0 - XW'(1);
    assign y_down  = (y0 == Y_MAX) ? (WRAP_EN ? '0 : y0)    : y0 + YW'(1);
    assign y_up    = (y0 == '0)    ? (WRAP_EN ? Y_MAX : y0) : y0 - YW'(1);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_t'(cmd) == CMD_LOAD) ? ST_FILL : ST_OUT;
                end
            end
            ST_FILL: begin
                if (fill_last) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                // The edge that drops the last beat may already take the next command.
                if (view_done) begin
                    if (cmd_valid) begin
                        accept    = 1'b1;
                        state_nxt = (cmd_t'(cmd) == CMD_LOAD) ? ST_FILL : ST_OUT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        if (mode == MODE_FIT) begin
            px = AW'(c) * AW'(SX) + AW'(SX / 2);
            py = AW'(r) * AW'(SY) + AW'(SY / 2);
        end else begin
            px = AW'(x0) + AW'(c);
            py = AW'(y0) + AW'(r);
        end
        rd_addr = py * AW'(IMG_W) + px;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            mode         <= MODE_FIT;
            x0           <= X_CTR;
            y0           <= Y_CTR;
            r            <= '0;
            c            <= '0;
            view_done    <= 1'b0;
            fill_addr    <= '0;
            busy         <= 1'b0;
            output_valid <= 1'b0;
            dataout      <= '0;
        end else begin
            state <= state_nxt;

            unique case (state)
                ST_FILL: begin
                    fill_addr <= fill_addr + AW'(1);
                    if (fill_last) begin
                        mode <= MODE_FIT;
                        x0   <= X_CTR;
                        y0   <= Y_CTR;
                    end
                end
                ST_OUT: begin
                    if (!view_done) begin
                        dataout      <= mem[rd_addr];
                        output_valid <= 1'b1;
                        if (last_beat) begin
                            view_done <= 1'b1;
                        end else if (c == LAST_IDX) begin
                            c <= '0;
                            r <= r + CW'(1);
                        end else begin
                            c <= c + CW'(1);
                        end
                    end else begin
                        output_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Acceptance overrides the end-of-view clears above.
            if (accept) begin
                busy      <= 1'b1;
                r         <= '0;
                c         <= '0;
                view_done <= 1'b0;
                fill_addr <= '0;
                unique case (cmd_t'(cmd))
                    CMD_SHIFT_RIGHT: if (mode == MODE_ZOOM) x0 <= x_right;
                    CMD_SHIFT_LEFT:  if (mode == MODE_ZOOM) x0 <= x_left;
                    CMD_SHIFT_UP:    if (mode == MODE_ZOOM) y0 <= y_up;
                    CMD_SHIFT_DOWN:  if (mode == MODE_ZOOM) y0 <= y_down;
                    CMD_ZOOM_FIT:    mode <= MODE_FIT;
                    CMD_ZOOM_IN: begin
                        if (mode == MODE_FIT) begin
                            mode <= MODE_ZOOM;
                            x0   <= X_CTR;
                            y0   <= Y_CTR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: image storage has no reset; its contents are only meaningful after a LOAD.
    always_ff @(posedge clk) begin
        if (state == ST_FILL) mem[fill_addr] <= datain;
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param at default parameters; image pixel = raster address.
// Expected origins follow LCD_WRAP_EN when the bench is built with it.
module tb_lcd_ctrl_param;

    localparam int IMG_W = 12;
    localparam int IMG_H = 9;
    localparam int WIN   = 4;
    localparam int DW    = 8;
    localparam int BEATS = WIN * WIN;

    localparam logic [2:0] C_LOAD = 3'd0, C_REFLASH = 3'd1, C_RIGHT = 3'd2, C_LEFT = 3'd3,
                           C_UP = 3'd4, C_DOWN = 3'd5, C_FIT = 3'd6, C_ZOOM = 3'd7;

    logic          clk;
    logic          reset;
    logic [2:0]    cmd;
    logic          cmd_valid;
    logic [DW-1:0] datain;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    int vec_cnt    = 0;
    int miscompare = 0;
    int exp_pix [BEATS];
    int got_pix [BEATS];

    lcd_ctrl_param #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .datain       (datain),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIT: SX=3, SY=2, so pixel (r,c) sits at x=3c+1, y=2r+1.
    task automatic expect_fit();
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                exp_pix[r*WIN+c] = (2*r + 1) * IMG_W + (3*c + 1);
    endtask

    task automatic expect_zoom(input int x0, input int y0);
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                exp_pix[r*WIN+c] = (y0 + r) * IMG_W + (x0 + c);
    endtask

    // Issues one command, feeds raster pixels, collects beats until busy drops.
    // exp_cyc is the number of edges from acceptance to the edge where busy falls.
    task automatic do_cmd(input logic [2:0] code, input string tag, input int exp_cyc,
                          input bit poke_busy);
        int j;
        int nb;
        @(negedge clk);
        cmd       = code;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        j  = 0;
        nb = 0;
        while (1) begin
            if (output_valid) begin
                if (nb < BEATS) got_pix[nb] = int'(dataout);
                nb++;
            end
            if (!busy || j >= 400) break;
            datain = DW'(j);
            if (poke_busy && j == 5) begin
                cmd       = C_ZOOM;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        cmd_valid = 1'b0;
        check({tag, "_busy_cycles"}, j, exp_cyc);
        check({tag, "_beat_count"}, nb, BEATS);
        for (int k = 0; k < BEATS && k < nb; k++)
            check($sformatf("%s_beat%0d", tag, k), got_pix[k], exp_pix[k]);
    endtask

`ifdef LCD_WRAP_EN
    int right_x [6] = '{5, 6, 7, 8, 0, 1};
    int up_y    [4] = '{1, 0, 5, 0};
`else
    int right_x [6] = '{5, 6, 7, 8, 8, 8};
    int up_y    [4] = '{1, 0, 0, 1};
`endif

    initial begin
        logic [2:0] ud [4];
        ud = '{C_UP, C_UP, C_UP, C_DOWN};
        reset     = 1'b1;
        cmd       = '0;
        cmd_valid = 1'b0;
        datain    = '0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dataout", int'(dataout), 0);
        check("rst_valid", int'(output_valid), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;

        // LOAD: 108 fill edges, 16 beats, busy falls 125 edges after acceptance.
        expect_fit();
        check("fit_first_literal", exp_pix[0], 8'h0D);
        do_cmd(C_LOAD, "load_fit", IMG_W*IMG_H + BEATS + 1, 1'b0);

        expect_zoom(4, 2);
        do_cmd(C_ZOOM, "zoom_in", BEATS + 1, 1'b0);
        check("zoom_last_literal", got_pix[BEATS-1], 8'h43);
        do_cmd(C_ZOOM, "zoom_again", BEATS + 1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            expect_zoom(right_x[i], 2);
            do_cmd(C_RIGHT, $sformatf("right%0d", i), BEATS + 1, 1'b0);
        end

        expect_fit();
        do_cmd(C_FIT, "zoom_fit", BEATS + 1, 1'b0);
        expect_zoom(4, 2);
        do_cmd(C_ZOOM, "recentre", BEATS + 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_zoom(4, up_y[i]);
            do_cmd(ud[i], $sformatf("updown%0d", i), BEATS + 1, 1'b0);
        end

        // Busy handling: shift in FIT re-emits FIT; a ZOOM_IN poked mid-view is ignored.
        expect_fit();
        do_cmd(C_FIT, "fit_again", BEATS + 1, 1'b0);
        do_cmd(C_LEFT, "left_in_fit", BEATS + 1, 1'b1);
        do_cmd(C_REFLASH, "after_poke", BEATS + 1, 1'b0);

        // Reset asserted during the fifth beat of a zoom view.
        expect_zoom(4, 2);
        do_cmd(C_ZOOM, "zoom_pre_rst", BEATS + 1, 1'b0);
        @(negedge clk);
        cmd       = C_REFLASH;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_beat5_valid", int'(output_valid), 1);
        check("mid_beat5_data", int'(dataout), 3*IMG_W + 4);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", int'(output_valid), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_data", int'(dataout), 0);
        @(negedge clk);
        reset = 1'b1;
        expect_fit();
        do_cmd(C_REFLASH, "post_rst_fit", BEATS + 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare);
        $finish;
    end

endmodule
